// File: rtl/fetch_redirect_unit.sv
// Fetch-side PC register and IF/ID pipeline register. Execute-stage redirects
// (PCSrcE) load the branch/JAL/JALR target, flush IF/ID and are counted.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic [1:0]       PCSrcE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      ALUResultE,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             FlushD,
  output logic             FlushE,
  output logic             TargetMisaligned,
  output logic [CNT_W-1:0] RedirectCount
);

  logic        redirect;
  logic [31:0] pcPlus4F;
  logic [31:0] redirectTarget;

  // PCSrcE = 11 is reserved and behaves like sequential fetch.
  assign redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign pcPlus4F = PCF + 32'd4;
  assign FlushD   = redirect;
  assign FlushE   = redirect;

  always_comb begin
    redirectTarget = PCTargetE;
    if (PCSrcE == 2'b10) begin
      // JALR clears bit 0 of rs1+imm.
      redirectTarget = {ALUResultE[31:1], 1'b0};
    end
  end

  // Redirect overrides StallF: the wrong-path fetch must be abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (redirect) begin
      PCF <= redirectTarget;
    end else if (!StallF) begin
      PCF <= pcPlus4F;
    end
  end

  // IF/ID priority: flush > stall > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
    end else if (redirect) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= pcPlus4F;
    end
  end

  // Status: sticky misaligned-target flag and saturating redirect counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TargetMisaligned <= 1'b0;
      RedirectCount    <= '0;
    end else begin
      if (redirect && (redirectTarget[1:0] != 2'b00)) begin
        TargetMisaligned <= 1'b1;
      end
      if (redirect && (RedirectCount != {CNT_W{1'b1}})) begin
        RedirectCount <= RedirectCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: a vector table for the main flow
// plus hand-written sequences for counter saturation and mid-cycle reset.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        StallD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        FlushD;
  logic        FlushE;
  logic        TargetMisaligned;
  logic [15:0] RedirectCount;

  localparam logic [31:0] NOP = 32'h00000013;

  fetch_redirect_unit #(
    .RESET_PC (32'h00000000),
    .NOP_INSTR(32'h00000013),
    .CNT_W    (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .StallF          (StallF),
    .StallD          (StallD),
    .PCSrcE          (PCSrcE),
    .PCTargetE       (PCTargetE),
    .ALUResultE      (ALUResultE),
    .InstrF          (InstrF),
    .PCF             (PCF),
    .InstrD          (InstrD),
    .PCD             (PCD),
    .PCPlus4D        (PCPlus4D),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .TargetMisaligned(TargetMisaligned),
    .RedirectCount   (RedirectCount)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: a fixed scramble of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A0003;
  endfunction

  assign InstrF = mem(PCF);

  typedef struct {
    logic        stallF;
    logic        stallD;
    logic [1:0]  pcSrc;
    logic [31:0] target;
    logic [31:0] aluRes;
    logic        expFlush;
    logic [31:0] expPCF;
    logic [31:0] expInstrD;
    logic [31:0] expPCD;
    logic [31:0] expPCPlus4D;
    logic        expMis;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecs[$];
  int   nAssert = 0;
  int   nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic sf, input logic sd, input logic [1:0] src,
                        input logic [31:0] tgt, input logic [31:0] alu, input logic fl,
                        input logic [31:0] pcf, input logic [31:0] ins, input logic [31:0] pcd,
                        input logic [31:0] p4d, input logic mis, input logic [15:0] cnt);
    vec_t v;
    v.stallF = sf; v.stallD = sd; v.pcSrc = src; v.target = tgt; v.aluRes = alu;
    v.expFlush = fl; v.expPCF = pcf; v.expInstrD = ins; v.expPCD = pcd;
    v.expPCPlus4D = p4d; v.expMis = mis; v.expCnt = cnt;
    vecs.push_back(v);
  endtask

  // Driver: inputs change 1ns after the edge, checks happen away from the edge.
  task automatic applyVec(input vec_t v, input int idx);
    StallF = v.stallF; StallD = v.stallD; PCSrcE = v.pcSrc;
    PCTargetE = v.target; ALUResultE = v.aluRes;
    #1;
    check($sformatf("v%0d FlushD", idx), {31'd0, FlushD}, {31'd0, v.expFlush});
    check($sformatf("v%0d FlushE", idx), {31'd0, FlushE}, {31'd0, v.expFlush});
    @(posedge clk); #1;
    check($sformatf("v%0d PCF", idx), PCF, v.expPCF);
    check($sformatf("v%0d InstrD", idx), InstrD, v.expInstrD);
    check($sformatf("v%0d PCD", idx), PCD, v.expPCD);
    check($sformatf("v%0d PCPlus4D", idx), PCPlus4D, v.expPCPlus4D);
    check($sformatf("v%0d Misaligned", idx), {31'd0, TargetMisaligned}, {31'd0, v.expMis});
    check($sformatf("v%0d Count", idx), {16'd0, RedirectCount}, {16'd0, v.expCnt});
  endtask

  task automatic checkReset(input string tag);
    check({tag, " PCF"}, PCF, 32'h0);
    check({tag, " InstrD"}, InstrD, NOP);
    check({tag, " PCD"}, PCD, 32'h0);
    check({tag, " PCPlus4D"}, PCPlus4D, 32'h0);
    check({tag, " Misaligned"}, {31'd0, TargetMisaligned}, 32'h0);
    check({tag, " Count"}, {16'd0, RedirectCount}, 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; PCSrcE = 2'b00;
    PCTargetE = 32'h0; ALUResultE = 32'h0;

    // Vector table: sf sd src target alu | flush PCF InstrD PCD PCPlus4D mis cnt
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h4,   mem(32'h0),   32'h0,   32'h4,   0, 16'd0);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h8,   mem(32'h4),   32'h4,   32'h8,   0, 16'd0);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'hC,   mem(32'h8),   32'h8,   32'hC,   0, 16'd0);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h10,  mem(32'hC),   32'hC,   32'h10,  0, 16'd0);
    addVec(0, 0, 2'b01, 32'h200, 32'h0,   1, 32'h200, NOP,          32'h0,   32'h0,   0, 16'd1);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h204, mem(32'h200), 32'h200, 32'h204, 0, 16'd1);
    addVec(0, 0, 2'b10, 32'h0,   32'h305, 1, 32'h304, NOP,          32'h0,   32'h0,   0, 16'd2);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h308, mem(32'h304), 32'h304, 32'h308, 0, 16'd2);
    addVec(0, 0, 2'b01, 32'h402, 32'h0,   1, 32'h402, NOP,          32'h0,   32'h0,   1, 16'd3);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h406, mem(32'h402), 32'h402, 32'h406, 1, 16'd3);
    addVec(1, 1, 2'b00, 32'h0,   32'h0,   0, 32'h406, mem(32'h402), 32'h402, 32'h406, 1, 16'd3);
    addVec(1, 1, 2'b00, 32'h0,   32'h0,   0, 32'h406, mem(32'h402), 32'h402, 32'h406, 1, 16'd3);
    addVec(1, 1, 2'b00, 32'h0,   32'h0,   0, 32'h406, mem(32'h402), 32'h402, 32'h406, 1, 16'd3);
    addVec(1, 1, 2'b01, 32'h80,  32'h0,   1, 32'h80,  NOP,          32'h0,   32'h0,   1, 16'd4);
    addVec(0, 0, 2'b11, 32'h500, 32'h600, 0, 32'h84,  mem(32'h80),  32'h80,  32'h84,  1, 16'd4);
    addVec(1, 0, 2'b00, 32'h0,   32'h0,   0, 32'h84,  mem(32'h84),  32'h84,  32'h88,  1, 16'd4);
    addVec(0, 1, 2'b00, 32'h0,   32'h0,   0, 32'h88,  mem(32'h84),  32'h84,  32'h88,  1, 16'd4);
    addVec(0, 0, 2'b01, 32'hFFFFFFFC, 32'h0, 1, 32'hFFFFFFFC, NOP, 32'h0, 32'h0, 1, 16'd5);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   mem(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h0, 1, 16'd5);
    addVec(0, 0, 2'b00, 32'h0,   32'h0,   0, 32'h4,   mem(32'h0),   32'h0,   32'h4,   1, 16'd5);

    doReset();
    checkReset("reset");

    foreach (vecs[i]) applyVec(vecs[i], i);

    // Counter saturation: 65534 redirects reach 0xFFFE, three more saturate.
    doReset();
    PCSrcE = 2'b01; PCTargetE = 32'h100;
    repeat (65534) @(posedge clk);
    #1;
    check("sat pre", {16'd0, RedirectCount}, 32'h0000FFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat %0d", k), {16'd0, RedirectCount}, 32'h0000FFFF);
    end
    PCSrcE = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("sat hold", {16'd0, RedirectCount}, 32'h0000FFFF);

    // Misaligned redirect, a few sequential cycles, then reset mid-cycle.
    PCSrcE = 2'b01; PCTargetE = 32'h101;
    @(posedge clk); #1;
    check("mis set", {31'd0, TargetMisaligned}, 32'h1);
    check("mis PCF", PCF, 32'h101);
    PCSrcE = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("mis sticky", {31'd0, TargetMisaligned}, 32'h1);
    check("pre-rst PCD", PCD, 32'h109);
    #2 rst = 1'b1;
    PCSrcE = 2'b10;
    #1;
    checkReset("async rst");
    check("rst FlushD", {31'd0, FlushD}, 32'h1);
    check("rst FlushE", {31'd0, FlushE}, 32'h1);
    @(posedge clk); #1;
    checkReset("held rst");
    PCSrcE = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst PCF", PCF, 32'h4);
    check("post-rst InstrD", InstrD, mem(32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
